// File: rtl/con_bus_arbiter.sv
// con_bus_arbiter: burst-locked round-robin arbiter that shares one external
// con_valid/con_ready/con_data load channel between the kernel (K) and input (I) loaders.
// Ports: clk, arst_n_in (async, active-low); con_valid/con_data in, con_ready out;
//   req_k/req_i, len_k/len_i in; k_valid/i_valid, k_data/i_data out; k_ready/i_ready in;
//   grant_k/grant_i, burst_done, beats_k/beats_i out.
// Optional macro CON_ARB_BEAT_STATS_EN builds the saturating beats_k/beats_i counters;
//   without it both counters read 0.
module con_bus_arbiter #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              arst_n_in,
    input  logic              con_valid,
    input  logic [DATA_W-1:0] con_data,
    output logic              con_ready,
    input  logic              req_k,
    input  logic              req_i,
    input  logic [LEN_W-1:0]  len_k,
    input  logic [LEN_W-1:0]  len_i,
    output logic              k_valid,
    output logic              i_valid,
    input  logic              k_ready,
    input  logic              i_ready,
    output logic [DATA_W-1:0] k_data,
    output logic [DATA_W-1:0] i_data,
    output logic              grant_k,
    output logic              grant_i,
    output logic              burst_done,
    output logic [CNT_W-1:0]  beats_k,
    output logic [CNT_W-1:0]  beats_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_K = 2'd1,
        GNT_I = 2'd2
    } state_t;

    localparam logic SIDE_K = 1'b0;
    localparam logic SIDE_I = 1'b1;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               rr_last_q, rr_last_d;
    logic               beat;
    logic               last_beat;

    assign beat      = con_valid & con_ready;
    assign last_beat = beat & (beat_cnt_q == '0);

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            rr_last_q  <= SIDE_I;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            rr_last_q  <= rr_last_d;
        end
    end

    // On a last beat the other requester gets priority, so back-to-back
    // bursts alternate without an idle cycle in between.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        rr_last_d  = rr_last_q;
        unique case (state_q)
            IDLE: begin
                if (req_k && (!req_i || rr_last_q == SIDE_I)) begin
                    state_d    = GNT_K;
                    beat_cnt_d = len_k;
                end else if (req_i) begin
                    state_d    = GNT_I;
                    beat_cnt_d = len_i;
                end
            end
            GNT_K: begin
                if (last_beat) begin
                    rr_last_d = SIDE_K;
                    if (req_i) begin
                        state_d    = GNT_I;
                        beat_cnt_d = len_i;
                    end else if (req_k) begin
                        state_d    = GNT_K;
                        beat_cnt_d = len_k;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q - LEN_W'(1);
                end
            end
            GNT_I: begin
                if (last_beat) begin
                    rr_last_d = SIDE_I;
                    if (req_k) begin
                        state_d    = GNT_K;
                        beat_cnt_d = len_k;
                    end else if (req_i) begin
                        state_d    = GNT_I;
                        beat_cnt_d = len_i;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q - LEN_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant_k    = (state_q == GNT_K);
    assign grant_i    = (state_q == GNT_I);
    assign burst_done = last_beat;

    // Pure passthrough: the owner sees the external beat in the same cycle.
    always_comb begin
        con_ready = 1'b0;
        k_valid   = 1'b0;
        i_valid   = 1'b0;
        k_data    = '0;
        i_data    = '0;
        unique case (state_q)
            GNT_K: begin
                con_ready = k_ready;
                k_valid   = con_valid;
                k_data    = con_data;
            end
            GNT_I: begin
                con_ready = i_ready;
                i_valid   = con_valid;
                i_data    = con_data;
            end
            default: begin
                con_ready = 1'b0;
            end
        endcase
    end

`ifdef CON_ARB_BEAT_STATS_EN
    logic [CNT_W-1:0] beats_k_q, beats_k_d;
    logic [CNT_W-1:0] beats_i_q, beats_i_d;

    always_comb begin
        beats_k_d = beats_k_q;
        beats_i_d = beats_i_q;
        if (beat && grant_k && beats_k_q != '1) begin
            beats_k_d = beats_k_q + CNT_W'(1);
        end
        if (beat && grant_i && beats_i_q != '1) begin
            beats_i_d = beats_i_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            beats_k_q <= '0;
            beats_i_q <= '0;
        end else begin
            beats_k_q <= beats_k_d;
            beats_i_q <= beats_i_d;
        end
    end

    assign beats_k = beats_k_q;
    assign beats_i = beats_i_q;
`else
    assign beats_k = '0;
    assign beats_i = '0;
`endif

endmodule
